// File: rtl/operand_issue_pkg.sv
// -----------------------------------------------------------------------------
// operand_issue_pkg
// Shared definitions for the operand issue stage:
//   - RV32 major opcode constants (OP_*)
//   - dec_use_t : which register fields an instruction reads / writes
//   - decode_use(): opcode + rd field -> dec_use_t
// -----------------------------------------------------------------------------
package operand_issue_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic rd_we;
    } dec_use_t;

    // rd_we is already qualified with rd != 0, so x0 is never tracked.
    function automatic dec_use_t decode_use(input logic [6:0] opcode, input logic [4:0] rd);
        dec_use_t u;
        u = '0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: u.rd_we = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                u.use_rs1 = 1'b1;
                u.rd_we   = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
            end
            OP_OP: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
                u.rd_we   = 1'b1;
            end
            OP_MISC_MEM, OP_SYSTEM: u = '0;
            default: u = '0;
        endcase
        u.rd_we = u.rd_we & (rd != 5'd0);
        return u;
    endfunction

endpackage

// File: rtl/operand_issue_if.sv
// -----------------------------------------------------------------------------
// operand_issue_if
// Bundles every non-clock signal of the issue stage:
//   fetch side     : in_valid/in_ready/in_instr/in_pc
//   register file  : rf_r1/rf_r2 (addresses), rf_out_r1/rf_out_r2 (data)
//   writeback      : wb_valid/wb_rd/wb_data
//   redirect       : flush
//   execute side   : out_valid/out_ready/out_pc/out_instr/out_rs1_val/
//                    out_rs2_val/out_rd/out_rd_we
// modport slave  : the issue stage itself
// modport master : the surrounding pipeline (fetch, regfile, execute, wb)
// -----------------------------------------------------------------------------
interface operand_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      rf_r1;
    logic [4:0]      rf_r2;
    logic [XLEN-1:0] rf_out_r1;
    logic [XLEN-1:0] rf_out_r2;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [4:0]      out_rd;
    logic            out_rd_we;

    modport slave (
        input  in_valid, in_instr, in_pc, rf_out_r1, rf_out_r2,
               wb_valid, wb_rd, wb_data, flush, out_ready,
        output in_ready, rf_r1, rf_r2, out_valid, out_pc, out_instr,
               out_rs1_val, out_rs2_val, out_rd, out_rd_we
    );

    modport master (
        output in_valid, in_instr, in_pc, rf_out_r1, rf_out_r2,
               wb_valid, wb_rd, wb_data, flush, out_ready,
        input  in_ready, rf_r1, rf_r2, out_valid, out_pc, out_instr,
               out_rs1_val, out_rs2_val, out_rd, out_rd_we
    );
endinterface

// File: rtl/operand_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_issue_scoreboard
// Busy bit per architectural register (bit 0 permanently clear).
// Ports:
//   clk, rst_n            clock, async active-low reset
//   set_en/set_idx        mark a register in flight (issue)
//   clr_en/clr_idx        writeback completion
//   fclr_en/fclr_idx      release the destination of a squashed entry
//   rs1_idx/rs2_idx/rd_idx -> rs1_busy/rs2_busy/rd_busy  combinational lookups
// -----------------------------------------------------------------------------
module operand_issue_scoreboard #(
    parameter int NREG = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic       fclr_en,
    input  logic [4:0] fclr_idx,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rs2_idx,
    input  logic [4:0] rd_idx,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Clears are applied first so a same-index set in the same cycle wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en)  busy_d[clr_idx]  = 1'b0;
        if (fclr_en) busy_d[fclr_idx] = 1'b0;
        if (set_en)  busy_d[set_idx]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];
    assign rd_busy  = busy_q[rd_idx];
endmodule

// File: rtl/operand_issue.sv
// -----------------------------------------------------------------------------
// operand_issue
// Issue stage in front of the integer register file: decodes register usage,
// drives the register-file read addresses, stalls on RAW/WAW hazards against
// the in-flight scoreboard and captures the operands into a one-entry
// valid/ready register feeding execute.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    operand_issue_if.slave (fetch, regfile, writeback, flush, execute)
// Build option:
//   OPERAND_ISSUE_WB_BYPASS_EN  forward wb_data to a source being written back
//                               in the same cycle (no extra bubble)
// -----------------------------------------------------------------------------
module operand_issue
    import operand_issue_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_issue_if.slave bus
);
    dec_use_t        dec_p0;
    logic [4:0]      rs1_p0, rs2_p0, rd_p0;
    logic            fwd1_p0, fwd2_p0;
    logic            rs1_busy_p0, rs2_busy_p0, rd_busy_p0;
    logic            hazard_p0, ready_p0, accept_p0;
    logic [XLEN-1:0] op1_p0, op2_p0;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1, instr_p1, rs1_val_p1, rs2_val_p1;
    logic [4:0]      rd_p1;
    logic            rd_we_p1;

    // ---- p0: decode, hazard check, operand select ----
    assign rs1_p0 = bus.in_instr[19:15];
    assign rs2_p0 = bus.in_instr[24:20];
    assign rd_p0  = bus.in_instr[11:7];
    assign dec_p0 = decode_use(bus.in_instr[6:0], rd_p0);

    assign bus.rf_r1 = rs1_p0;
    assign bus.rf_r2 = rs2_p0;

`ifdef OPERAND_ISSUE_WB_BYPASS_EN
    assign fwd1_p0 = bus.wb_valid & (bus.wb_rd == rs1_p0) & (rs1_p0 != 5'd0);
    assign fwd2_p0 = bus.wb_valid & (bus.wb_rd == rs2_p0) & (rs2_p0 != 5'd0);
`else
    assign fwd1_p0 = 1'b0;
    assign fwd2_p0 = 1'b0;
`endif

    operand_issue_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (accept_p0 & dec_p0.rd_we),
        .set_idx  (rd_p0),
        .clr_en   (bus.wb_valid & (bus.wb_rd != 5'd0)),
        .clr_idx  (bus.wb_rd),
        .fclr_en  (bus.flush & vld_p1 & rd_we_p1),
        .fclr_idx (rd_p1),
        .rs1_idx  (rs1_p0),
        .rs2_idx  (rs2_p0),
        .rd_idx   (rd_p0),
        .rs1_busy (rs1_busy_p0),
        .rs2_busy (rs2_busy_p0),
        .rd_busy  (rd_busy_p0)
    );

    // WAW stalls too, which keeps at most one outstanding writer per register.
    assign hazard_p0 = (dec_p0.use_rs1 & rs1_busy_p0 & ~fwd1_p0)
                     | (dec_p0.use_rs2 & rs2_busy_p0 & ~fwd2_p0)
                     | (dec_p0.rd_we & rd_busy_p0);
    assign ready_p0  = ~bus.flush & ~hazard_p0 & (~vld_p1 | bus.out_ready);
    assign accept_p0 = bus.in_valid & ready_p0;
    assign bus.in_ready = ready_p0;

    always_comb begin
        op1_p0 = '0;
        op2_p0 = '0;
        if (dec_p0.use_rs1) op1_p0 = fwd1_p0 ? bus.wb_data : bus.rf_out_r1;
        if (dec_p0.use_rs2) op2_p0 = fwd2_p0 ? bus.wb_data : bus.rf_out_r2;
    end

    // ---- p1: output register toward execute ----
    // Flush takes priority over a simultaneous pop: the held entry is squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            pc_p1      <= '0;
            instr_p1   <= '0;
            rs1_val_p1 <= '0;
            rs2_val_p1 <= '0;
            rd_p1      <= '0;
            rd_we_p1   <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1     <= 1'b1;
            pc_p1      <= bus.in_pc;
            instr_p1   <= bus.in_instr;
            rs1_val_p1 <= op1_p0;
            rs2_val_p1 <= op2_p0;
            rd_p1      <= rd_p0;
            rd_we_p1   <= dec_p0.rd_we;
        end else if (vld_p1 & bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_pc      = pc_p1;
    assign bus.out_instr   = instr_p1;
    assign bus.out_rs1_val = rs1_val_p1;
    assign bus.out_rs2_val = rs2_val_p1;
    assign bus.out_rd      = rd_p1;
    assign bus.out_rd_we   = rd_we_p1;

`ifndef SYNTHESIS
    // Upstream must hold a stalled instruction unchanged until it is taken.
    logic            stall_q;
    logic [XLEN-1:0] stall_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= 1'b0;
        else        stall_q <= bus.in_valid & ~ready_p0;
    end

    always_ff @(posedge clk) begin
        stall_instr_q <= bus.in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst_n && stall_q)
            assert (bus.in_valid && (bus.in_instr == stall_instr_q));
    end
`endif
endmodule

// File: tb/tb_operand_issue.sv
module tb_operand_issue;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_issue_if #(.XLEN(32)) bus ();

    operand_issue #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file model: combinational read, write on the writeback strobe.
    logic [31:0] rf [32];

    function automatic logic [31:0] rf_init(input int i);
        return (i == 0) ? 32'h0 : (32'h1111_0000 + 32'(i));
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign bus.rf_out_r1 = rf[bus.rf_r1];
    assign bus.rf_out_r2 = rf[bus.rf_r2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    function automatic logic [31:0] busy();
        return 32'(dut.u_sb.busy_q);
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] busy;
    } vec_t;

    vec_t tbl [12];

    localparam logic [31:0] RF3 = 32'h1111_0003;
    localparam logic [31:0] RF4 = 32'h1111_0004;

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{enc_r(7'd0, 5'd3, 5'd4, 3'b010, 5'd0, 7'b0100011), RF4, RF3, 5'd0, 1'b0, 32'h0};     // sw x3,0(x4)
        tbl[1]  = '{enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011), 32'd5, 32'd0, 5'd0, 1'b0, 32'h0};      // lw x0,0(x1)
        tbl[2]  = '{enc_u(20'h12345, 5'd7, 7'b0110111), 32'd0, 32'd0, 5'd7, 1'b1, 32'h80};               // lui x7
        tbl[3]  = '{enc_u(20'h00001, 5'd8, 7'b0010111), 32'd0, 32'd0, 5'd8, 1'b1, 32'h180};              // auipc x8
        tbl[4]  = '{enc_u(20'h00000, 5'd9, 7'b1101111), 32'd0, 32'd0, 5'd9, 1'b1, 32'h380};              // jal x9
        tbl[5]  = '{enc_i(12'd0, 5'd4, 3'b000, 5'd10, 7'b1100111), RF4, 32'd0, 5'd10, 1'b1, 32'h780};    // jalr x10,0(x4)
        tbl[6]  = '{enc_r(7'd0, 5'd4, 5'd3, 3'b000, 5'd0, 7'b1100011), RF3, RF4, 5'd0, 1'b0, 32'h780};   // beq x3,x4,0
        tbl[7]  = '{enc_r(7'h20, 5'd4, 5'd3, 3'b000, 5'd11, 7'b0110011), RF3, RF4, 5'd11, 1'b1, 32'hF80}; // sub x11,x3,x4
        tbl[8]  = '{enc_i(12'd0, 5'd3, 3'b000, 5'd13, 7'b0001111), 32'd0, 32'd0, 5'd13, 1'b0, 32'hF80};  // misc-mem
        tbl[9]  = '{enc_i(12'd0, 5'd3, 3'b001, 5'd14, 7'b1110011), 32'd0, 32'd0, 5'd14, 1'b0, 32'hF80};  // system
        tbl[10] = '{enc_r(7'd0, 5'd4, 5'd3, 3'b000, 5'd15, 7'b1010111), 32'd0, 32'd0, 5'd15, 1'b0, 32'hF80}; // unknown
        tbl[11] = '{enc_i(12'd1, 5'd3, 3'b000, 5'd12, 7'b0010011), RF3, 32'd0, 5'd12, 1'b1, 32'h1F80};   // addi x12,x3,1

        // Reset
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        cyc(); cyc();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_rs1", bus.out_rs1_val, 32'd0);
        chk("rst_busy", busy(), 32'd0);
        rst_n = 1'b1;
        cyc();

        // addi x1,x0,5
        present(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 32'h100);
        #1 chk("addi_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_pc", bus.out_pc, 32'h100);
        chk("addi_rd", 32'(bus.out_rd), 32'd1);
        chk("addi_rd_we", 32'(bus.out_rd_we), 32'd1);
        chk("addi_rs1", bus.out_rs1_val, 32'd0);
        chk("addi_busy", busy(), 32'h2);

        // add x2,x1,x1 : RAW on x1
        present(enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2, 7'b0110011), 32'h104);
        #1 chk("raw_ready0", 32'(bus.in_ready), 32'd0);
        chk("raw_rf_r1", 32'(bus.rf_r1), 32'd1);
        chk("raw_rf_r2", 32'(bus.rf_r2), 32'd1);
        cyc();
        chk("raw_popped", 32'(bus.out_valid), 32'd0);
        chk("raw_ready1", 32'(bus.in_ready), 32'd0);
        wb(1'b1, 5'd1, 32'd5);
        #1;
`ifdef OPERAND_ISSUE_WB_BYPASS_EN
        chk("raw_ready_wb", 32'(bus.in_ready), 32'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
`else
        chk("raw_ready_wb", 32'(bus.in_ready), 32'd0);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        #1 chk("raw_ready_after", 32'(bus.in_ready), 32'd1);
        cyc();
`endif
        bus.in_valid = 1'b0;
        chk("raw_valid", 32'(bus.out_valid), 32'd1);
        chk("raw_pc", bus.out_pc, 32'h104);
        chk("raw_rd", 32'(bus.out_rd), 32'd2);
        chk("raw_rs1", bus.out_rs1_val, 32'd5);
        chk("raw_rs2", bus.out_rs2_val, 32'd5);
        chk("raw_busy", busy(), 32'h4);
        wb(1'b1, 5'd2, rf_init(2));
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        chk("wb2_busy", busy(), 32'h0);
        chk("wb2_popped", 32'(bus.out_valid), 32'd0);

        // Table of back-to-back hazard-free instructions
        for (int i = 0; i < 12; i++) begin
            present(tbl[i].instr, 32'h200 + 32'(4 * i));
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'd1);
            chk($sformatf("v%0d_rf_r1", i), 32'(bus.rf_r1), 32'(tbl[i].instr[19:15]));
            chk($sformatf("v%0d_rf_r2", i), 32'(bus.rf_r2), 32'(tbl[i].instr[24:20]));
            cyc();
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("v%0d_pc", i), bus.out_pc, 32'h200 + 32'(4 * i));
            chk($sformatf("v%0d_instr", i), bus.out_instr, tbl[i].instr);
            chk($sformatf("v%0d_rs1", i), bus.out_rs1_val, tbl[i].rs1v);
            chk($sformatf("v%0d_rs2", i), bus.out_rs2_val, tbl[i].rs2v);
            chk($sformatf("v%0d_rd", i), 32'(bus.out_rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d_rd_we", i), 32'(bus.out_rd_we), 32'(tbl[i].rd_we));
            chk($sformatf("v%0d_busy", i), busy(), tbl[i].busy);
        end
        bus.in_valid = 1'b0;
        for (int r = 7; r <= 12; r++) begin
            wb(1'b1, 5'(r), rf_init(r));
            cyc();
        end
        wb(1'b0, 5'd0, 32'd0);
        chk("tbl_busy_clear", busy(), 32'h0);
        chk("tbl_popped", 32'(bus.out_valid), 32'd0);

        // Execute back-pressure for 3 cycles
        present(enc_i(12'd7, 5'd3, 3'b000, 5'd13, 7'b0010011), 32'h300);
        #1 chk("stl_ready0", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.out_ready = 1'b0;
        present(enc_i(12'd8, 5'd3, 3'b000, 5'd14, 7'b0010011), 32'h304);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("stl%0d_ready", k), 32'(bus.in_ready), 32'd0);
            cyc();
            chk($sformatf("stl%0d_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stl%0d_pc", k), bus.out_pc, 32'h300);
            chk($sformatf("stl%0d_rd", k), 32'(bus.out_rd), 32'd13);
            chk($sformatf("stl%0d_rs1", k), bus.out_rs1_val, RF3);
        end
        bus.out_ready = 1'b1;
        #1 chk("stl_release_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        chk("stl_next_valid", 32'(bus.out_valid), 32'd1);
        chk("stl_next_pc", bus.out_pc, 32'h304);

        // Flush while holding addi x5
        present(enc_i(12'd1, 5'd3, 3'b000, 5'd5, 7'b0010011), 32'h308);
        #1 chk("fl_ready0", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        present(enc_i(12'd2, 5'd3, 3'b000, 5'd15, 7'b0010011), 32'h30C);
        #1 chk("fl_ready", 32'(bus.in_ready), 32'd0);
        chk("fl_busy5_before", (busy() >> 5) & 32'd1, 32'd1);
        cyc();
        bus.flush = 1'b0;
        chk("fl_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_busy5", (busy() >> 5) & 32'd1, 32'd0);
        chk("fl_busy15", (busy() >> 15) & 32'd1, 32'd0);
        #1 chk("fl_ready_after", 32'(bus.in_ready), 32'd1);
        cyc();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("fl_next_valid", 32'(bus.out_valid), 32'd1);
        chk("fl_next_pc", bus.out_pc, 32'h30C);
        chk("fl_busy", busy(), 32'h0000_E000);
        wb(1'b1, 5'd13, 32'h13); cyc();
        wb(1'b1, 5'd14, 32'h14); cyc();
        wb(1'b1, 5'd15, 32'h15); cyc();
        wb(1'b1, 5'd20, 32'h20); cyc();
        wb(1'b0, 5'd0, 32'd0);
        chk("fl_busy_clear", busy(), 32'h0);

        // Accept addi x6 while a stray writeback to x6 arrives: set wins
        present(enc_i(12'd3, 5'd3, 3'b000, 5'd6, 7'b0010011), 32'h310);
        wb(1'b1, 5'd6, rf_init(6));
        #1 chk("sw_ready", 32'(bus.in_ready), 32'd1);
        cyc();
        wb(1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b0;
        chk("sw_busy", busy(), 32'h40);
        chk("sw_rd", 32'(bus.out_rd), 32'd6);

        // Reset asserted in the middle of a stall
        present(enc_r(7'd0, 5'd6, 5'd6, 3'b000, 5'd16, 7'b0110011), 32'h314);
        #1 chk("rs_ready", 32'(bus.in_ready), 32'd0);
        cyc();
        chk("rs_hold_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", 32'(bus.out_valid), 32'd0);
        chk("rs_busy", busy(), 32'h0);
        chk("rs_pc", bus.out_pc, 32'h0);
        chk("rs_rd_we", 32'(bus.out_rd_we), 32'd0);
        bus.in_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- Issue stage directly upstream of the integer register file. Decodes rs1/rs2/rd usage from the fetched instruction and drives the register-file read addresses.
- Tracks in-flight destination registers with a 31-bit scoreboard and stalls on RAW/WAW hazards.
- Captures the operands into a one-entry valid/ready pipeline register that feeds execute.
- Writeback reports completion through the same strobe that drives the register-file write port.

Parameters:
XLEN, 32, data width of PC, instruction and operands
NREG, 32, architectural register count; x0 is hardwired zero and never tracked

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  XLEN  instruction word
in_pc  in  XLEN  instruction PC
rf_r1  out  5  register-file read address 1, combinational from in_instr[19:15]
rf_r2  out  5  register-file read address 2, combinational from in_instr[24:20]
rf_out_r1  in  XLEN  register-file read data 1
rf_out_r2  in  XLEN  register-file read data 2
wb_valid  in  1  writeback strobe, identical to the register-file enable_write
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
flush  in  1  squash the held entry (branch redirect)
out_valid  out  1  entry valid toward execute
out_ready  in  1  execute accepts the entry
out_pc  out  XLEN  registered PC
out_instr  out  XLEN  registered instruction
out_rs1_val  out  XLEN  registered operand 1
out_rs2_val  out  XLEN  registered operand 2
out_rd  out  5  registered destination
out_rd_we  out  1  registered "writes rd" flag; 0 whenever rd==0

Behaviour:
- Reset (async, rst_n=0): out_valid=0; all out_* data outputs 0; busy[31:1]=0.
- Decode by opcode[6:0]:
  - LUI, AUIPC, JAL: rd only.
  - JALR, LOAD, OP-IMM: rs1 and rd.
  - BRANCH, STORE: rs1 and rs2.
  - OP: rs1, rs2 and rd.
  - MISC-MEM, SYSTEM, unknown: no operands, no rd.
- A source or destination field equal to 0 never hazards.
- hazard = (use_rs1 & busy[rs1] & !fwd1) | (use_rs2 & busy[rs2] & !fwd2) | (rd_we & busy[rd]).
  - WAW stalls, so one outstanding writer per register at most.
- Accept condition: accept = in_valid & in_ready. in_ready = !flush & !hazard & (!out_valid | out_ready).
  - Accept is combinational on the current-cycle inputs.
- On accept: the output register loads pc, instr, rd and rd_we. Operands load from the bypass or the register file (see Optional Feature). Unused operand fields load 0. Latency is 1 cycle.
- Pop: when out_valid & out_ready & !accept, out_valid goes to 0.
- Stall: hold all out_* stable while out_valid & !out_ready.
- Scoreboard:
  - An accept with rd_we sets busy[rd].
  - wb_valid with wb_rd!=0 clears busy[wb_rd].
  - Set and clear of the same index in the same cycle: set wins.
  - wb_valid for a non-busy register is legal and has no effect.
- Flush:
  - Clears out_valid in that cycle.
  - If the squashed entry had out_rd_we=1, clears busy[out_rd] (the squashed entry will never write back).
  - No accept occurs in a flush cycle.
  - Flush with out_valid=0 only blocks accept.
- Sticky stall: in_valid must not drop and in_instr must not change while in_valid & !in_ready; flag as an assertion.

Optional Feature:
- Macro: OPERAND_ISSUE_WB_BYPASS_EN.
- With the macro defined: fwd1 = wb_valid & wb_rd==rs1 & rs1!=0; fwd2 likewise for rs2.
  - A forwarded operand is taken from wb_data instead of the register file, which still holds the old value that cycle.
  - A RAW hazard on a register being written back resolves in the same cycle.
- Without the macro: fwd1 = fwd2 = 0. The stage stalls through the writeback cycle and reads the register file the following cycle (one extra bubble).

Decomposition:
- Package operand_issue_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_MISC_MEM, OP_SYSTEM);
  - a typedef for the decoded-use record {use_rs1, use_rs2, rd_we};
  - the function decode_use(opcode, rd).
- One sub-module, operand_issue_scoreboard: busy vector, set/clear/flush-clear ports, two source lookups and one destination lookup.

Test Plan:
- Reset then "addi x1,x0,5" at pc 0x100 with out_ready=1 → next cycle out_valid=1, out_pc=0x100, out_rd=1, out_rd_we=1, out_rs1_val=0; busy[1]=1.
- With busy[1] set, present "add x2,x1,x1" → in_ready=0 until wb_valid, wb_rd=1, wb_data=5.
  - With bypass: accepted in the wb cycle, out_rs1_val=out_rs2_val=5.
  - Without bypass: accepted one cycle later with the register-file value 5.
- "sw x3,0(x4)" → out_rd_we=0 and the scoreboard is unchanged; a following "lw x0,0(x1)" also leaves busy unchanged, out_rd_we=0.
- Hold out_ready=0 for 3 cycles with a valid entry → out_* stable, in_ready=0; release → next instruction accepted in the same cycle as the pop.
- Flush while holding "addi x5,..." (busy[5]=1) → out_valid=0 and busy[5]=0 next cycle; a simultaneous in_valid is not accepted.
- In the same cycle, accept "addi x6,..." and receive wb_valid with wb_rd=6 for an older writer → busy[6] remains 1; assert rst_n low mid-stall → out_valid=0 and all busy bits clear immediately.
